trace_event_collector: RTL and testbench

- Parametrised successor to the single-core fetch/execute tracer.
- Observes NUM_STAGES pipeline stages. Each stage has a request/done pair and a PC.
- Classifies per-stage activity into single-cycle, multicycle-start, multicycle-end and abort events, and timestamps each one.
- Events are buffered through per-stage pending slots, a round-robin arbiter and a FIFO, then leave on a valid/ready record stream.
- Sits beside the core; its output feeds the trace sink or the DPI bridge.

---
 rtl/trace_event_collector.sv | 225 ++++++++++++++++++++++
 tb/tb_trace_event_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_event_collector.sv
// Multi-stage pipeline tracer: classifies per-stage activity into timestamped events
// and funnels them through pending slots, a round-robin arbiter and a FIFO to a valid/ready stream.
module trace_event_collector #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned SID_W      = 4,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               trace_en_i,
    input  logic [NUM_STAGES-1:0]              stage_req_i,
    input  logic [NUM_STAGES-1:0]              stage_done_i,
    input  logic [NUM_STAGES*32-1:0]           stage_pc_i,
    output logic                               ev_valid_o,
    input  logic                               ev_ready_i,
    output logic [TS_W+SID_W+2+32-1:0]         ev_data_o,
    output logic [DROP_W-1:0]                  drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level_o
);
    localparam int unsigned REC_W = TS_W + SID_W + 2 + 32;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned PTR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        KIND_SINGLE = 2'd0,
        KIND_START  = 2'd1,
        KIND_END    = 2'd2,
        KIND_ABORT  = 2'd3
    } kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SID_W-1:0] sid;
        logic [1:0]       kind;
        logic [31:0]      pc;
    } rec_t;

    logic                  active_q;
    logic [TS_W-1:0]       ts_q;
    state_e                state_q [NUM_STAGES];
    state_e                state_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] ev_fire;
    kind_e                 ev_kind [NUM_STAGES];

    rec_t                  slot_q [NUM_STAGES];
    rec_t                  slot_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] slot_full_q, slot_full_d;
    logic [NUM_STAGES-1:0] drop;
    logic [CNT_W-1:0]      n_drop;
    logic [DROP_W:0]       drop_sum;
    logic [DROP_W-1:0]     drop_q, drop_d;

    logic [NUM_STAGES-1:0] gnt;
    logic                  gnt_any, can_push;
    logic [PTR_W-1:0]      gnt_idx, ptr_q, ptr_d, idx;
    logic [PTR_W:0]        idx_sum;

    rec_t                  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d, count_after_pop;
    logic                  pop, push;
    rec_t                  push_rec;
    logic                  ev_valid_q, ev_valid_d;
    logic [REC_W-1:0]      ev_data_q, ev_data_d;

    // Per-stage IDLE/MULTI classifier; trace_en low parks every stage in IDLE silently
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            state_d[i] = state_q[i];
            ev_fire[i] = 1'b0;
            ev_kind[i] = KIND_SINGLE;
            if (!trace_en_i) begin
                state_d[i] = ST_IDLE;
            end else if (active_q) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (stage_req_i[i]) begin
                            ev_fire[i] = 1'b1;
                            if (stage_done_i[i]) begin
                                ev_kind[i] = KIND_SINGLE;
                            end else begin
                                ev_kind[i] = KIND_START;
                                state_d[i] = ST_MULTI;
                            end
                        end
                    end
                    ST_MULTI: begin
                        if (!stage_req_i[i]) begin
                            ev_fire[i] = 1'b1;
                            ev_kind[i] = KIND_ABORT;
                            state_d[i] = ST_IDLE;
                        end else if (stage_done_i[i]) begin
                            ev_fire[i] = 1'b1;
                            ev_kind[i] = KIND_END;
                            state_d[i] = ST_IDLE;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    assign pop = ev_valid_q & ev_ready_i;

    // Round-robin scan starting at ptr_q; a full FIFO can still accept when it pops this cycle
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
        idx_sum  = '0;
        can_push = (count_q != LVL_W'(FIFO_DEPTH)) || pop;
        for (int k = 0; k < NUM_STAGES; k++) begin
            idx_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx_sum >= (PTR_W+1)'(NUM_STAGES)) begin
                idx_sum = idx_sum - (PTR_W+1)'(NUM_STAGES);
            end
            idx = idx_sum[PTR_W-1:0];
            if (can_push && !gnt_any && slot_full_q[idx]) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
                gnt_idx  = idx;
            end
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_STAGES - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Pending slots: a slot freed by this cycle's grant can take the new event
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            slot_full_d[i] = slot_full_q[i] & ~gnt[i];
            slot_d[i]      = slot_q[i];
            drop[i]        = 1'b0;
            if (ev_fire[i]) begin
                if (slot_full_d[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    slot_full_d[i]  = 1'b1;
                    slot_d[i].ts    = ts_q;
                    slot_d[i].sid   = SID_W'(i);
                    slot_d[i].kind  = ev_kind[i];
                    slot_d[i].pc    = stage_pc_i[32*i +: 32];
                end
            end
        end
        n_drop   = CNT_W'($countones(drop));
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    // FIFO with a registered head: output stage reloads from the entry behind any pop
    always_comb begin
        push            = gnt_any;
        push_rec        = slot_q[gnt_idx];
        count_after_pop = count_q - LVL_W'(pop);
        count_d         = count_after_pop + LVL_W'(push);
        rd_ptr_d        = rd_ptr_q + AW'(pop);
        wr_ptr_d        = wr_ptr_q + AW'(push);
        ev_valid_d      = (count_after_pop != '0);
        ev_data_d       = ev_valid_d ? mem_q[rd_ptr_d] : ev_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            ts_q        <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                state_q[i] <= ST_IDLE;
            end
            slot_full_q <= '0;
            drop_q      <= '0;
            ptr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_valid_q  <= 1'b0;
            ev_data_q   <= '0;
        end else begin
            active_q    <= 1'b1;
            if (active_q) begin
                ts_q <= ts_q + TS_W'(1);
            end
            for (int i = 0; i < NUM_STAGES; i++) begin
                state_q[i] <= state_d[i];
            end
            slot_full_q <= slot_full_d;
            drop_q      <= drop_d;
            ptr_q       <= ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ev_valid_q  <= ev_valid_d;
            ev_data_q   <= ev_data_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by slot_full_q and count_q
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            slot_q[i] <= slot_d[i];
        end
        if (push) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    assign ev_valid_o   = ev_valid_q;
    assign ev_data_o    = ev_data_q;
    assign drop_count_o = drop_q;
    assign fifo_level_o = count_q;

endmodule

// File: tb/tb_trace_event_collector.sv
// Directed bench for trace_event_collector: expected records are queued as stimulus is
// driven and compared in order as the DUT hands them over on the valid/ready stream.
module tb_trace_event_collector;
    localparam int unsigned NS    = 2;
    localparam int unsigned REC_W = 16 + 4 + 2 + 32;
    localparam logic [1:0] K_SINGLE = 2'd0;
    localparam logic [1:0] K_START  = 2'd1;
    localparam logic [1:0] K_END    = 2'd2;
    localparam logic [1:0] K_ABORT  = 2'd3;

    logic             clk;
    logic             rst_n;
    logic             trace_en;
    logic [NS-1:0]    stage_req;
    logic [NS-1:0]    stage_done;
    logic [NS*32-1:0] stage_pc;
    logic             ev_valid;
    logic             ev_ready;
    logic [REC_W-1:0] ev_data;
    logic [15:0]      drop_count;
    logic [3:0]       fifo_level;

    logic [REC_W-1:0] exp_q[$];
    int unsigned      n_total = 0;
    int unsigned      n_pass  = 0;
    int unsigned      n_fail  = 0;
    logic             m_active;
    logic [15:0]      m_ts;

    trace_event_collector #(
        .NUM_STAGES(2), .FIFO_DEPTH(8), .TS_W(16), .SID_W(4), .DROP_W(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trace_en_i  (trace_en),
        .stage_req_i (stage_req),
        .stage_done_i(stage_done),
        .stage_pc_i  (stage_pc),
        .ev_valid_o  (ev_valid),
        .ev_ready_i  (ev_ready),
        .ev_data_o   (ev_data),
        .drop_count_o(drop_count),
        .fifo_level_o(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: value the DUT will stamp on an event sampled at the next edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_ts     <= '0;
        end else begin
            m_active <= 1'b1;
            if (m_active) m_ts <= m_ts + 16'd1;
        end
    end

    function automatic logic [REC_W-1:0] mk(input logic [15:0] ts, input logic [3:0] sid,
                                            input logic [1:0] kind, input logic [31:0] pc);
        return {ts, sid, kind, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted record must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            chk("sb_has_expectation", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("sb_record", 64'(ev_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [15:0] t0;
        rst_n      = 1'b0;
        trace_en   = 1'b1;
        stage_req  = '0;
        stage_done = '0;
        stage_pc   = '0;
        ev_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(ev_valid), 64'd0);
        chk("rst_data",  64'(ev_data), 64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        rst_n = 1'b1;
        tick();

        // SINGLE on stage 0 at ts=5 and its two-edge latency
        repeat (5) tick();
        stage_req  = 2'b01;
        stage_done = 2'b01;
        stage_pc[31:0] = 32'h0000_1000;
        exp_q.push_back(mk(16'd5, 4'd0, K_SINGLE, 32'h0000_1000));
        tick();
        stage_req  = '0;
        stage_done = '0;
        chk("lat_valid_t0", 64'(ev_valid), 64'd0);
        tick();
        chk("lat_valid_t1", 64'(ev_valid), 64'd0);
        chk("lat_level_t1", 64'(fifo_level), 64'd1);
        tick();
        chk("lat_valid_t2", 64'(ev_valid), 64'd1);
        chk("lat_data_t2", 64'(ev_data), 64'(mk(16'd5, 4'd0, K_SINGLE, 32'h0000_1000)));
        tick();
        chk("pop_valid", 64'(ev_valid), 64'd0);
        chk("pop_level", 64'(fifo_level), 64'd0);

        // START then END on stage 1 three cycles apart
        t0 = m_ts;
        stage_pc[63:32] = 32'h8000_0010;
        stage_req  = 2'b10;
        stage_done = 2'b00;
        exp_q.push_back(mk(t0, 4'd1, K_START, 32'h8000_0010));
        repeat (3) tick();
        stage_done = 2'b10;
        exp_q.push_back(mk(t0 + 16'd3, 4'd1, K_END, 32'h8000_0010));
        tick();
        stage_req  = '0;
        stage_done = '0;
        wait_drain(20);

        // ABORT when stage 0 drops req mid-MULTI
        t0 = m_ts;
        stage_pc[31:0] = 32'h0000_2000;
        stage_req  = 2'b01;
        exp_q.push_back(mk(t0, 4'd0, K_START, 32'h0000_2000));
        tick();
        stage_req  = 2'b00;
        exp_q.push_back(mk(t0 + 16'd1, 4'd0, K_ABORT, 32'h0000_2000));
        tick();
        wait_drain(20);

        // trace_en low mid-MULTI: no ABORT, stage returns to IDLE (next req&done is SINGLE)
        t0 = m_ts;
        stage_req  = 2'b01;
        exp_q.push_back(mk(t0, 4'd0, K_START, 32'h0000_2000));
        tick();
        trace_en  = 1'b0;
        stage_req = 2'b00;
        tick();
        trace_en   = 1'b1;
        stage_req  = 2'b01;
        stage_done = 2'b01;
        exp_q.push_back(mk(t0 + 16'd2, 4'd0, K_SINGLE, 32'h0000_2000));
        tick();
        stage_req  = '0;
        stage_done = '0;
        wait_drain(20);
        chk("en_level", 64'(fifo_level), 64'd0);

        // Fill: both stages SINGLE every cycle with ev_ready low
        do_reset();
        ev_ready   = 1'b0;
        stage_pc   = {32'h0000_3100, 32'h0000_3000};
        stage_req  = 2'b11;
        stage_done = 2'b11;
        exp_q.push_back(mk(16'd0, 4'd0, K_SINGLE, 32'h0000_3000));
        exp_q.push_back(mk(16'd0, 4'd1, K_SINGLE, 32'h0000_3100));
        for (int n = 2; n < 8; n++) begin
            exp_q.push_back(mk(16'(n - 1), 4'(n % 2), K_SINGLE,
                               (n % 2 == 0) ? 32'h0000_3000 : 32'h0000_3100));
        end
        exp_q.push_back(mk(16'd7, 4'd0, K_SINGLE, 32'h0000_3000));
        exp_q.push_back(mk(16'd8, 4'd1, K_SINGLE, 32'h0000_3100));
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 8) begin
                chk("fill_level", 64'(fifo_level), 64'd8);
                chk("fill_drop", 64'(drop_count), 64'd8);
            end
            if (k > 8) begin
                chk("full_drop_step", 64'(drop_count), 64'(8 + 2 * (k - 8)));
            end
        end
        stage_req  = '0;
        stage_done = '0;
        ev_ready   = 1'b1;
        wait_drain(40);
        chk("drained_level", 64'(fifo_level), 64'd0);
        chk("drained_valid", 64'(ev_valid), 64'd0);

        // Reset with five records queued
        ev_ready   = 1'b0;
        stage_pc[31:0] = 32'h0000_4000;
        stage_req  = 2'b01;
        stage_done = 2'b01;
        repeat (5) tick();
        stage_req  = '0;
        stage_done = '0;
        tick();
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        chk("pre_rst_drop", 64'(drop_count), 64'd14);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_valid", 64'(ev_valid), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        tick();
        ev_ready   = 1'b1;
        stage_req  = 2'b01;
        stage_done = 2'b01;
        exp_q.push_back(mk(16'd0, 4'd0, K_SINGLE, 32'h0000_4000));
        tick();
        stage_req  = '0;
        stage_done = '0;
        wait_drain(20);

        // Drop counter saturation
        do_reset();
        ev_ready   = 1'b0;
        stage_req  = 2'b11;
        stage_done = 2'b11;
        repeat (32772) tick();
        chk("sat_below", 64'(drop_count), 64'hFFFE);
        tick();
        chk("sat_hit", 64'(drop_count), 64'hFFFF);
        tick();
        chk("sat_hold", 64'(drop_count), 64'hFFFF);
        chk("sat_level", 64'(fifo_level), 64'd8);
        stage_req  = '0;
        stage_done = '0;
        tick();
        chk("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
